ifu_plru_sets: RTL and testbench

IFU_PLRU_SETS -- requirements
Module: ifu_plru_sets

---
 rtl/ifu_plru_sets.sv | 146 ++++++++++++++
 tb/tb_ifu_plru_sets.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_plru_sets.sv
// Tree pseudo-LRU replacement state for a set-associative instruction cache.
// Hits and fills touch the tree, misses pick a victim, and a flush clears one set per cycle.
module ifu_plru_sets #(
    parameter  int WAYS_NUM = 16,
    parameter  int SETS_NUM = 4,
    localparam int WAY_W    = $clog2(WAYS_NUM),
    localparam int SET_W    = $clog2(SETS_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SET_W-1:0] set_idx,
    input  logic             update_tree,
    input  logic [WAY_W-1:0] hit_cl,
    input  logic             cache_miss,
    input  logic             fill_valid,
    input  logic [SET_W-1:0] fill_set,
    input  logic [WAY_W-1:0] fill_way,
    input  logic             flush_req,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_valid,
    output logic             busy
);

    // state | meaning
    // IDLE  | serve hits, fills and victim requests
    // FLUSH | clear tree and valid bits of set cnt_q, one set per cycle
    localparam int NODES = WAYS_NUM - 1;
    localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [NODES-1:0]    tree_q  [SETS_NUM];
    logic [NODES-1:0]    tree_d  [SETS_NUM];
    logic [WAYS_NUM-1:0] valid_q [SETS_NUM];
    logic [WAYS_NUM-1:0] valid_d [SETS_NUM];

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [SET_W-1:0] cnt_q;
    logic [SET_W-1:0] cnt_d;
    logic [WAY_W-1:0] victim_way_q;
    logic [WAY_W-1:0] victim_d;
    logic             victim_valid_q;
    logic             req_ok;

    // Walk root to leaf along way w, pointing each visited node at the other subtree.
    function automatic logic [NODES-1:0] tree_touch(input logic [NODES-1:0] t,
                                                    input logic [WAY_W-1:0] w);
        logic [NODES-1:0] r;
        logic [WAY_W-1:0] path;
        int               n;
        r    = t;
        path = w;
        n    = 0;
        for (int d = 0; d < WAY_W; d++) begin
            r[IDX_W'(n)] = ~path[WAY_W-1];
            n            = 2 * n + (path[WAY_W-1] ? 2 : 1);
            path         = path << 1;
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] tree_walk(input logic [NODES-1:0] t);
        logic [WAY_W-1:0] w;
        logic             b;
        int               n;
        w = '0;
        n = 0;
        for (int d = 0; d < WAY_W; d++) begin
            b = t[IDX_W'(n)];
            w = (w << 1) | WAY_W'(b);
            n = 2 * n + (b ? 2 : 1);
        end
        return w;
    endfunction

    function automatic logic [WAY_W-1:0] first_invalid(input logic [WAYS_NUM-1:0] v);
        logic [WAY_W-1:0] w;
        w = '0;
        for (int i = WAYS_NUM - 1; i >= 0; i--) begin
            if (!v[WAY_W'(i)]) w = WAY_W'(i);
        end
        return w;
    endfunction

    // A pending flush_req pre-empts every other request in the same cycle.
    assign req_ok = (state_q == ST_IDLE) && !flush_req;

    always_comb begin
        victim_d = (&valid_q[set_idx]) ? tree_walk(tree_q[set_idx])
                                       : first_invalid(valid_q[set_idx]);
    end

    always_comb begin
        for (int s = 0; s < SETS_NUM; s++) begin
            tree_d[SET_W'(s)]  = tree_q[SET_W'(s)];
            valid_d[SET_W'(s)] = valid_q[SET_W'(s)];
        end
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_FLUSH) begin
            tree_d[cnt_q]  = '0;
            valid_d[cnt_q] = '0;
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == SET_W'(SETS_NUM - 1)) state_d = ST_IDLE;
        end else if (flush_req) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
        end else begin
            if (fill_valid) begin
                valid_d[fill_set][fill_way] = 1'b1;
                tree_d[fill_set]            = tree_touch(tree_q[fill_set], fill_way);
            end
            // Applied on top of the fill so the hit path wins on shared nodes.
            if (update_tree) tree_d[set_idx] = tree_touch(tree_d[set_idx], hit_cl);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS_NUM; s++) begin
                tree_q[SET_W'(s)]  <= '0;
                valid_q[SET_W'(s)] <= '0;
            end
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            victim_way_q   <= '0;
            victim_valid_q <= 1'b0;
        end else begin
            for (int s = 0; s < SETS_NUM; s++) begin
                tree_q[SET_W'(s)]  <= tree_d[SET_W'(s)];
                valid_q[SET_W'(s)] <= valid_d[SET_W'(s)];
            end
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            victim_valid_q <= req_ok && cache_miss;
            if (req_ok && cache_miss) victim_way_q <= victim_d;
        end
    end

    assign victim_way   = victim_way_q;
    assign victim_valid = victim_valid_q;
    assign busy         = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_ifu_plru_sets.sv
// Directed bench for ifu_plru_sets (4 ways, 2 sets) against a range-based PLRU model.
module tb_ifu_plru_sets;

    localparam int WAYS  = 4;
    localparam int SETS  = 2;
    localparam int NODES = WAYS - 1;
    localparam int WAY_W = 2;
    localparam int SET_W = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [SET_W-1:0] set_idx = '0;
    logic             update_tree = 1'b0;
    logic [WAY_W-1:0] hit_cl = '0;
    logic             cache_miss = 1'b0;
    logic             fill_valid = 1'b0;
    logic [SET_W-1:0] fill_set = '0;
    logic [WAY_W-1:0] fill_way = '0;
    logic             flush_req = 1'b0;
    logic [WAY_W-1:0] victim_way;
    logic             victim_valid;
    logic             busy;

    always #5 clk = ~clk;

    ifu_plru_sets #(.WAYS_NUM(WAYS), .SETS_NUM(SETS)) dut (
        .clk(clk), .rst(rst), .set_idx(set_idx), .update_tree(update_tree),
        .hit_cl(hit_cl), .cache_miss(cache_miss), .fill_valid(fill_valid),
        .fill_set(fill_set), .fill_way(fill_way), .flush_req(flush_req),
        .victim_way(victim_way), .victim_valid(victim_valid), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    int m_tree  [SETS][NODES];
    bit m_valid [SETS][WAYS];
    int busy_left;
    bit exp_vv;
    int exp_vw;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int n = 0; n < NODES; n++) m_tree[s][n] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
        busy_left = 0;
        exp_vv    = 1'b0;
        exp_vw    = 0;
    endfunction

    // Each node splits its way range in half; an access points it at the half not containing w.
    function automatic void m_touch(input int s, input int w);
        int lo, hi, mid, node;
        lo = 0; hi = WAYS; node = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w < mid) begin
                m_tree[s][node] = 1; node = 2 * node + 1; hi = mid;
            end else begin
                m_tree[s][node] = 0; node = 2 * node + 2; lo = mid;
            end
        end
    endfunction

    function automatic int m_victim(input int s);
        int lo, hi, mid, node;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        lo = 0; hi = WAYS; node = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (m_tree[s][node] == 0) begin hi = mid; node = 2 * node + 1; end
            else begin lo = mid; node = 2 * node + 2; end
        end
        return lo;
    endfunction

    task automatic model_step();
        if (busy_left > 0) begin
            for (int n = 0; n < NODES; n++) m_tree[SETS - busy_left][n] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[SETS - busy_left][w] = 1'b0;
            busy_left--;
            exp_vv = 1'b0;
        end else if (flush_req) begin
            busy_left = SETS;
            exp_vv    = 1'b0;
        end else begin
            if (cache_miss) begin
                exp_vw = m_victim(int'(set_idx));
                exp_vv = 1'b1;
            end else begin
                exp_vv = 1'b0;
            end
            if (fill_valid) begin
                m_valid[int'(fill_set)][int'(fill_way)] = 1'b1;
                m_touch(int'(fill_set), int'(fill_way));
            end
            if (update_tree) m_touch(int'(set_idx), int'(hit_cl));
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("busy", busy, busy_left > 0);
            check("victim_valid", victim_valid, exp_vv);
            check("victim_way", victim_way, exp_vw);
        end
    end

    task automatic cycle(input bit fl, input bit ut, input int hc, input bit cm, input int si,
                         input bit fv, input int fs, input int fw);
        flush_req   = fl;
        update_tree = ut;
        hit_cl      = hc[WAY_W-1:0];
        cache_miss  = cm;
        set_idx     = si[SET_W-1:0];
        fill_valid  = fv;
        fill_set    = fs[SET_W-1:0];
        fill_way    = fw[WAY_W-1:0];
        @(posedge clk);
        model_step();
        #1;
        flush_req = 1'b0; update_tree = 1'b0; cache_miss = 1'b0; fill_valid = 1'b0;
    endtask

    task automatic miss(input int s);          cycle(0, 0, 0, 1, s, 0, 0, 0); endtask
    task automatic hit(input int s, input int w);  cycle(0, 1, w, 0, s, 0, 0, 0); endtask
    task automatic fill(input int s, input int w); cycle(0, 0, 0, 0, 0, 1, s, w); endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        #1 rst = 1'b1;
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_vv", victim_valid, 0);
        check("rst_vw", victim_way, 0);
        rst = 1'b0;

        // Empty set: lowest invalid way, one-cycle pulse.
        miss(0);
        check("empty_miss_vv", victim_valid, 1);
        check("empty_miss_vw", victim_way, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("pulse_drop", victim_valid, 0);

        for (int w = 0; w < WAYS; w++) fill(0, w);
        miss(0);
        check("full_miss_vw", victim_way, 0);
        hit(0, 0);
        miss(0);
        check("after_hit0_vw", victim_way, 2);

        // Set isolation, then back-to-back misses on two sets.
        hit(1, 3);
        miss(0);
        check("isolation_vw", victim_way, 2);
        miss(1);
        check("b2b_vv", victim_valid, 1);
        check("set1_empty_vw", victim_way, 0);

        // Flush: two busy cycles, misses ignored.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("flush_busy1", busy, 1);
        miss(0);
        check("flush_busy2", busy, 1);
        check("flush_no_vv1", victim_valid, 0);
        miss(0);
        check("flush_done", busy, 0);
        check("flush_no_vv2", victim_valid, 0);
        miss(0);
        check("post_flush_vv", victim_valid, 1);
        check("post_flush_vw", victim_way, 0);

        // Hit and miss in the same cycle: victim uses pre-update state.
        for (int w = 0; w < WAYS; w++) fill(0, w);
        cycle(0, 1, 0, 1, 0, 0, 0, 0);
        check("same_cycle_vw", victim_way, 0);
        miss(0);
        check("after_same_cycle_vw", victim_way, 2);

        // Fill way 3 and hit way 1 on set 0 together: hit owns the root.
        cycle(0, 1, 1, 0, 0, 1, 0, 3);
        miss(0);
        check("hit_wins_vw", victim_way, 2);

        // Fill on set 1 and hit on set 0 together.
        cycle(0, 1, 2, 0, 0, 1, 1, 0);
        miss(0);
        check("split_set0_vw", victim_way, 0);
        miss(1);
        check("split_set1_vw", victim_way, 1);

        // Flush together with miss and fill: only the flush happens.
        cycle(1, 0, 0, 1, 0, 1, 1, 1);
        check("flush_pri_vv", victim_valid, 0);
        check("flush_pri_busy", busy, 1);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 1), $urandom_range(0, WAYS - 1),
                  $urandom_range(0, 1), $urandom_range(0, SETS - 1), $urandom_range(0, 1),
                  $urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1));
        end
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset during the first flush cycle.
        fill(1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        m_reset();
        #1;
        check("rst_flush_busy", busy, 0);
        check("rst_flush_vv", victim_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        miss(1);
        check("rst_cleared_set1", victim_way, 0);
        miss(0);
        check("rst_cleared_set0", victim_way, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
